trace_buffer: RTL

Double-buffered store between the ray tracer (writer) and the per-row renderer (reader). The tracer pushes one trace result per screen row (wall ID, side, wall size, texture u) into the back bank through a valid/ready handshake. The renderer reads the front bank by row index with fixed one-cycle latency. Banks flip only on a swap request after the back bank is completely written, so the renderer never sees a half-traced frame.

---
 rtl/trace_buffer_pkg.sv | 36 +++
 rtl/trace_buffer_if.sv | 38 +++
 rtl/trace_buffer_bank_ram.sv | 31 +++
 rtl/trace_buffer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/trace_buffer_pkg.sv
// raybox_defs: field layout shared by the ray tracer, the trace buffer and
// the row renderer. One trace entry is 20 bits, packed as
// {wall[19:18], side[17], size[16:6], texu[5:0]}.
package raybox_defs;

  localparam int WALL_W  = 2;
  localparam int SIDE_W  = 1;
  localparam int SIZE_W  = 11;
  localparam int TEXU_W  = 6;
  localparam int ENTRY_W = WALL_W + SIDE_W + SIZE_W + TEXU_W;

  // Bit positions inside a packed entry.
  localparam int TEXU_LSB = 0;
  localparam int SIZE_LSB = TEXU_LSB + TEXU_W;
  localparam int SIDE_BIT = SIZE_LSB + SIZE_W;
  localparam int WALL_LSB = SIDE_BIT + SIDE_W;

  // One entry per traced screen row.
  localparam int DEPTH_DEFAULT = 480;
  localparam int AW_DEFAULT    = 10;

  // Member order matches the bit positions above (first member = MSBs).
  typedef struct packed {
    logic [WALL_W-1:0] wall;
    logic              side;
    logic [SIZE_W-1:0] size;
    logic [TEXU_W-1:0] texu;
  } trace_entry_t;

  // Back-bank write state.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } wr_state_t;

endpackage

// File: rtl/trace_buffer_if.sv
// trace_buffer_if: bundles the tracer write channel, the vblank swap
// request/response and the renderer read channel.
//   master : tracer + renderer side (drives wr_*, swap, rd_addr)
//   slave  : trace_buffer side (drives wr_ready, swap_done/missed, rd_*)
interface trace_buffer_if
  import raybox_defs::*;
#(
  parameter int AW = AW_DEFAULT
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [WALL_W-1:0] wr_wall;
  logic              wr_side;
  logic [SIZE_W-1:0] wr_size;
  logic [TEXU_W-1:0] wr_texu;

  logic              swap;
  logic              swap_done;
  logic              swap_missed;

  logic [AW-1:0]     rd_addr;
  logic [WALL_W-1:0] rd_wall;
  logic              rd_side;
  logic [SIZE_W-1:0] rd_size;
  logic [TEXU_W-1:0] rd_texu;

  modport master (
    output wr_valid, wr_wall, wr_side, wr_size, wr_texu, swap, rd_addr,
    input  wr_ready, swap_done, swap_missed, rd_wall, rd_side, rd_size, rd_texu
  );

  modport slave (
    input  wr_valid, wr_wall, wr_side, wr_size, wr_texu, swap, rd_addr,
    output wr_ready, swap_done, swap_missed, rd_wall, rd_side, rd_size, rd_texu
  );

endinterface

// File: rtl/trace_buffer_bank_ram.sv
// trace_bank_ram: DEPTH x DW array, one write port, one registered read
// port. No reset on contents or read register so it maps onto block RAM
// or can be swapped for an SRAM macro.
//   clk   : clock
//   we    : write enable, stores wdata at waddr
//   raddr : read address, rdata valid one cycle later
module trace_bank_ram #(
  parameter int DEPTH = 480,
  parameter int AW    = 10,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    // Addresses >= DEPTH yield don't-care data; the owner masks them.
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/trace_buffer.sv
// trace_buffer: double-buffered per-row trace store. The tracer fills the
// back bank through a valid/ready handshake; the renderer reads the front
// bank with one-cycle latency. A swap flips banks only once the back bank
// is complete, so a half-traced frame is never visible.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : write channel, swap request/pulses, read channel
module trace_buffer
  import raybox_defs::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  trace_buffer_if.slave bus
);

  localparam logic [AW:0] LAST_IDX  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] DEPTH_VAL = (AW+1)'(DEPTH);

  wr_state_t   state_q, state_d;
  logic        front_sel_q, front_sel_d;
  logic        front_valid_q, front_valid_d;
  logic        back_full_q, back_full_d;
  logic        wr_ready_q, wr_ready_d;
  logic        swap_done_q, swap_done_d;
  logic        swap_missed_q, swap_missed_d;
  logic [AW:0] wptr_q, wptr_d;   // 0..DEPTH, one extra bit for DEPTH itself
  // Read-side qualifiers captured alongside the RAM read register.
  logic        rd_ok_q, rd_ok_d;
  logic        rd_sel_q, rd_sel_d;

  logic         wr_fire;
  trace_entry_t wr_entry;
  trace_entry_t rd_entry;
  logic [ENTRY_W-1:0] bank_rdata [2];

  assign wr_fire  = bus.wr_valid && wr_ready_q;
  assign wr_entry = '{wall: bus.wr_wall, side: bus.wr_side,
                      size: bus.wr_size, texu: bus.wr_texu};

  always_comb begin
    state_d       = state_q;
    front_sel_d   = front_sel_q;
    front_valid_d = front_valid_q;
    back_full_d   = back_full_q;
    wptr_d        = wptr_q;
    swap_done_d   = 1'b0;
    swap_missed_d = 1'b0;

    if (wr_fire) begin
      wptr_d = wptr_q + 1'b1;
      if (wptr_q == LAST_IDX) begin
        back_full_d = 1'b1;
        state_d     = ST_FULL;
      end
    end

    // Swap looks only at the pre-edge back_full, so a swap coinciding with
    // the final write is missed and the following swap succeeds. A write
    // and a successful swap can never coincide (back_full implies FULL).
    if (bus.swap) begin
      if (back_full_q) begin
        front_sel_d   = ~front_sel_q;
        front_valid_d = 1'b1;
        back_full_d   = 1'b0;
        wptr_d        = '0;
        state_d       = ST_FILL;
        swap_done_d   = 1'b1;
      end else begin
        swap_missed_d = 1'b1;
      end
    end

    wr_ready_d = (state_d == ST_FILL);
    // Uses pre-swap front selection/valid: a same-cycle read sees the old frame.
    rd_ok_d    = front_valid_q && ({1'b0, bus.rd_addr} < DEPTH_VAL);
    rd_sel_d   = front_sel_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_FILL;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      back_full_q   <= 1'b0;
      wptr_q        <= '0;
      wr_ready_q    <= 1'b1;
      swap_done_q   <= 1'b0;
      swap_missed_q <= 1'b0;
      rd_ok_q       <= 1'b0;
      rd_sel_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_sel_q   <= front_sel_d;
      front_valid_q <= front_valid_d;
      back_full_q   <= back_full_d;
      wptr_q        <= wptr_d;
      wr_ready_q    <= wr_ready_d;
      swap_done_q   <= swap_done_d;
      swap_missed_q <= swap_missed_d;
      rd_ok_q       <= rd_ok_d;
      rd_sel_q      <= rd_sel_d;
    end
  end

  // Bank gi is the back bank when front_sel != gi. Both banks are read
  // every cycle; the registered selector picks the front one.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      trace_bank_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (ENTRY_W)
      ) u_ram (
        .clk   (clk),
        .we    (wr_fire && (front_sel_q != 1'(gi))),
        .waddr (wptr_q[AW-1:0]),
        .wdata (wr_entry),
        .raddr (bus.rd_addr),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  assign rd_entry = rd_ok_q ? trace_entry_t'(bank_rdata[rd_sel_q]) : '0;

  assign bus.wr_ready    = wr_ready_q;
  assign bus.swap_done   = swap_done_q;
  assign bus.swap_missed = swap_missed_q;
  assign bus.rd_wall     = rd_entry.wall;
  assign bus.rd_side     = rd_entry.side;
  assign bus.rd_size     = rd_entry.size;
  assign bus.rd_texu     = rd_entry.texu;

endmodule
